// File: rtl/div32_seq_pkg.sv
// Shared types and constants for the sequential signed divider.
// Covers FSM states, iteration count, result word split and a magnitude helper.
package div32_seq_pkg;

    localparam int WIDTH    = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    // Rz layout: remainder to ZHigh, quotient to ZLow.
    localparam int ZHI_MSB = 2 * WIDTH - 1;
    localparam int ZHI_LSB = WIDTH;
    localparam int ZLO_MSB = WIDTH - 1;
    localparam int ZLO_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Unsigned magnitude; -2^(WIDTH-1) maps to exactly 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

endpackage

// File: rtl/div32_seq_if.sv
// Start/done handshake and operand/result bus between control unit and divider.
// Names are from the divider's point of view.
interface div32_seq_if;
    import div32_seq_pkg::*;

    logic                   i_start;
    logic [WIDTH-1:0]       i_ra;
    logic [WIDTH-1:0]       i_rb;
    logic [2*WIDTH-1:0]     o_rz;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_dz;

    modport master (
        output i_start, i_ra, i_rb,
        input  o_rz, o_busy, o_done, o_dz
    );

    modport slave (
        input  i_start, i_ra, i_rb,
        output o_rz, o_busy, o_done, o_dz
    );

endinterface

// File: rtl/div32_seq_step.sv
// One non-restoring iteration: shift {P,Q} left, then add or subtract the divisor
// depending on the sign of P before the shift.
module nr_div_step
    import div32_seq_pkg::*;
(
    input  logic [WIDTH:0]   i_p,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_p,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_d_ext;

    assign w_shift = {i_p[WIDTH-1:0], i_q_msb};
    assign w_d_ext = {1'b0, i_d};
    assign o_p     = i_p[WIDTH] ? (w_shift + w_d_ext) : (w_shift - w_d_ext);
    assign o_q_bit = ~o_p[WIDTH];

endmodule

// File: rtl/div32_seq.sv
// Sequential signed 32-bit non-restoring divider; Rz = {remainder, quotient}.
// FSM IDLE -> RUN (32 iterations) -> FIX (restore and sign) -> DONE; all outputs registered.
module div32_seq
    import div32_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    div32_seq_if.slave  bus
);

    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [WIDTH:0]       r_p;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_d;
    logic                 r_qneg;
    logic                 r_rneg;
    logic                 r_dz;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_rz;

    logic [WIDTH:0]       w_p_next;
    logic                 w_q_bit;
    logic [WIDTH-1:0]     w_rem_mag;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quo;

    nr_div_step u_step (
        .i_p     (r_p),
        .i_q_msb (r_q[WIDTH-1]),
        .i_d     (r_d),
        .o_p     (w_p_next),
        .o_q_bit (w_q_bit)
    );

    // A negative final partial remainder overshot by one divisor.
    assign w_rem_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d) : r_p[WIDTH-1:0];
    assign w_rem     = r_rneg ? -w_rem_mag : w_rem_mag;
    assign w_quo     = r_qneg ? -r_q : r_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rz    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_busy  <= 1'b1;
                        r_p     <= '0;
                        r_count <= '0;
                        r_dz    <= (bus.i_rb == '0);
                        if (bus.i_rb != '0) begin
                            r_q     <= abs_val(bus.i_ra);
                            r_d     <= abs_val(bus.i_rb);
                            r_qneg  <= bus.i_ra[WIDTH-1] ^ bus.i_rb[WIDTH-1];
                            r_rneg  <= bus.i_ra[WIDTH-1];
                            r_state <= RUN;
                        end else begin
                            r_q     <= bus.i_ra;
                            r_state <= FIX;
                        end
                    end
                end
                RUN: begin
                    r_p     <= w_p_next;
                    r_q     <= {r_q[WIDTH-2:0], w_q_bit};
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(DIV_ITER - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    if (r_dz) begin
                        r_rz[ZHI_MSB:ZHI_LSB] <= r_q;
                        r_rz[ZLO_MSB:ZLO_LSB] <= '1;
                    end else begin
                        r_rz[ZHI_MSB:ZHI_LSB] <= w_rem;
                        r_rz[ZLO_MSB:ZLO_LSB] <= w_quo;
                    end
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_rz   = r_rz;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_dz   = r_dz;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results, latency and handshake checks.
module tb_div32_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    div32_seq_if bus();

    div32_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed division truncating toward zero, remainder takes dividend sign.
    function automatic logic [63:0] model_div(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'sh8000_0000 && b == -32'sd1) return {32'h0, 32'h8000_0000};
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    // Transaction-level model: accepted start -> result after fixed latency.
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [63:0] m_rz   = '0;
    logic [63:0] m_pend = '0;
    logic        m_dz   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_rz   = '0;
            m_pend = '0;
            m_dz   = 1'b0;
        end else if (!m_busy) begin
            if (bus.i_start) begin
                m_pend = model_div(bus.i_ra, bus.i_rb);
                m_dz   = (bus.i_rb == 32'h0);
                m_left = m_dz ? 2 : 34;
                m_busy = 1'b1;
            end
        end else begin
            m_left--;
            if (m_left == 1) m_rz = m_pend;
            if (m_left == 0) m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 64'(bus.o_busy), 64'(m_busy));
            check("done", 64'(bus.o_done), 64'(m_busy && m_left == 1));
            check("dz",   64'(bus.o_dz),   64'(m_dz));
            check("rz",   bus.o_rz,        m_rz);
        end
    end

    // Issue one division; count cycles from the sampling edge to done.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_rz, input logic exp_dz, input int exp_lat);
        int n;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_ra    = a;
        bus.i_rb    = b;
        @(negedge clk);
        bus.i_start = 1'b0;
        n = 1;
        check("busy_c1", 64'(bus.o_busy), 64'd1);
        check("dz_c1",   64'(bus.o_dz),   64'(exp_dz));
        while (!bus.o_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("rz_lit",  bus.o_rz, exp_rz);
        check("dz_lit",  64'(bus.o_dz), 64'(exp_dz));
        @(negedge clk);
        check("idle_busy", 64'(bus.o_busy), 64'd0);
        check("rz_hold",   bus.o_rz, exp_rz);
    endtask

    initial begin
        int n;
        bus.i_start = 1'b0;
        bus.i_ra    = '0;
        bus.i_rb    = '0;
        repeat (2) @(negedge clk);
        check("rst_rz",   bus.o_rz, 64'h0);
        check("rst_busy", 64'(bus.o_busy), 64'd0);
        check("rst_done", 64'(bus.o_done), 64'd0);
        check("rst_dz",   64'(bus.o_dz),   64'd0);
        rst = 1'b0;

        do_div(32'd100,        32'd7,          64'h00000002_0000000E, 1'b0, 34);
        do_div(-32'sd100,      32'd7,          64'hFFFFFFFE_FFFFFFF2, 1'b0, 34);
        do_div(32'd100,        -32'sd7,        64'h00000002_FFFFFFF2, 1'b0, 34);
        do_div(32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 1'b0, 34);
        do_div(32'd7,          32'd100,        64'h00000007_00000000, 1'b0, 34);
        do_div(-32'sd7,        -32'sd2,        64'hFFFFFFFF_00000003, 1'b0, 34);
        do_div(32'd5,          32'd0,          64'h00000005_FFFFFFFF, 1'b1, 2);
        do_div(32'd100,        32'd7,          64'h00000002_0000000E, 1'b0, 34);

        // Start during a running division is ignored.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_ra    = 32'd100;
        bus.i_rb    = 32'd7;
        @(negedge clk);
        bus.i_start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        bus.i_start = 1'b1;
        bus.i_ra    = 32'd9;
        bus.i_rb    = 32'd3;
        @(negedge clk);
        n++;
        bus.i_start = 1'b0;
        while (!bus.o_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ign_latency", 64'(n), 64'd34);
        check("ign_rz",      bus.o_rz, 64'h00000002_0000000E);
        @(negedge clk);
        check("ign_no_second", 64'(bus.o_busy), 64'd0);

        // Asynchronous clear in the middle of a division.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_ra    = 32'd100;
        bus.i_rb    = 32'd7;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("clr_rz",   bus.o_rz, 64'h0);
        check("clr_busy", 64'(bus.o_busy), 64'd0);
        check("clr_done", 64'(bus.o_done), 64'd0);
        check("clr_dz",   64'(bus.o_dz),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_div(32'd9, 32'd3, 64'h00000000_00000003, 1'b0, 34);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
